// File: rtl/version_read_arbiter.sv
// version_read_arbiter: multi-version store with one writer and round-robin readers on one lookup path.
// Define VERSION_READ_ARBITER_STATS_EN to add hit/miss/reject counters.
module version_read_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4,
    parameter int VERSION_NUM   = 4,
    parameter int REQ_NUM       = 2,
    localparam int ID_W         = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rstN,
    input  logic                             i_wrValid,
    input  logic [VERSION_WIDTH-1:0]         i_wrVersion,
    input  logic [DATA_WIDTH-1:0]            i_wrData,
    output logic                             o_wrReady,
    output logic                             o_wrErr,
    input  logic [REQ_NUM-1:0]               i_reqValid,
    input  logic [REQ_NUM*VERSION_WIDTH-1:0] i_reqVersion,
    output logic [REQ_NUM-1:0]               o_reqReady,
    output logic                             o_rspValid,
    input  logic                             i_rspReady,
    output logic [ID_W-1:0]                  o_rspId,
    output logic                             o_rspHit,
    output logic [DATA_WIDTH-1:0]            o_rspData
`ifdef VERSION_READ_ARBITER_STATS_EN
    ,
    output logic [31:0]                      o_hitCount,
    output logic [31:0]                      o_missCount,
    output logic [15:0]                      o_rejCount
`endif
);
    localparam int SLOT_W = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1;
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
    state_t r_state, w_nextState;
    logic                     r_valid [VERSION_NUM];
    logic [VERSION_WIDTH-1:0] r_ver   [VERSION_NUM];
    logic [DATA_WIDTH-1:0]    r_data  [VERSION_NUM];
    logic [VERSION_WIDTH-1:0] w_reqVer [REQ_NUM];
    logic [VERSION_WIDTH-1:0] r_lastVer, r_reqVer, w_bestVer;
    logic                     r_lastVerValid, r_lastWasWrite;
    logic [ID_W-1:0]          r_rrPtr, r_reqId, w_gntId, w_idx;
    logic                     w_wrElig, w_wrOk, w_gntFound, w_readGo, w_tgtFound, w_hit;
    logic [SLOT_W-1:0]        w_tgt;
    logic [DATA_WIDTH-1:0]    w_hitData;

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_unpack
        assign w_reqVer[g] = i_reqVersion[g*VERSION_WIDTH +: VERSION_WIDTH];
    end

    // A write is held off only to give a waiting reader its turn after a write.
    always_comb begin
        w_wrElig   = (r_state == IDLE) && i_wrValid && !((|i_reqValid) && r_lastWasWrite);
        w_wrOk     = w_wrElig && (!r_lastVerValid || i_wrVersion > r_lastVer);
        w_gntFound = 1'b0;
        w_gntId    = '0;
        w_idx      = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_rrPtr) + k) % REQ_NUM);
            if (i_reqValid[w_idx]) begin
                w_gntFound = 1'b1;
                w_gntId    = w_idx;
            end
        end
        w_readGo   = (r_state == IDLE) && !w_wrElig && w_gntFound;
        o_reqReady = '0;
        if (w_readGo) o_reqReady[w_gntId] = 1'b1;
        o_wrReady  = w_wrElig;
        o_wrErr    = w_wrElig && !w_wrOk;
    end

    // Fill the lowest free slot; when full, evict the oldest (smallest) version.
    always_comb begin
        w_tgt      = '0;
        w_tgtFound = 1'b0;
        for (int s = VERSION_NUM - 1; s >= 0; s--) begin
            if (!r_valid[s]) begin
                w_tgtFound = 1'b1;
                w_tgt      = SLOT_W'(s);
            end
        end
        if (!w_tgtFound) begin
            for (int s = 1; s < VERSION_NUM; s++) begin
                if (r_ver[s] < r_ver[w_tgt]) w_tgt = SLOT_W'(s);
            end
        end
    end

    always_comb begin
        w_hit     = 1'b0;
        w_hitData = '0;
        w_bestVer = '0;
        for (int s = 0; s < VERSION_NUM; s++) begin
            if (r_valid[s] && r_ver[s] <= r_reqVer && (!w_hit || r_ver[s] > w_bestVer)) begin
                w_hit     = 1'b1;
                w_bestVer = r_ver[s];
                w_hitData = r_data[s];
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_readGo) w_nextState = LOOKUP;
            LOOKUP:  w_nextState = RESP;
            RESP:    if (i_rspReady) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_state        <= IDLE;
            r_lastVer      <= '0;
            r_lastVerValid <= 1'b0;
            r_lastWasWrite <= 1'b0;
            r_rrPtr        <= '0;
            r_reqId        <= '0;
            r_reqVer       <= '0;
            o_rspValid     <= 1'b0;
            o_rspId        <= '0;
            o_rspHit       <= 1'b0;
            o_rspData      <= '0;
            for (int s = 0; s < VERSION_NUM; s++) begin
                r_valid[s] <= 1'b0;
                r_ver[s]   <= '0;
                r_data[s]  <= '0;
            end
        end else begin
            r_state <= w_nextState;
            if (w_wrOk) begin
                r_valid[w_tgt] <= 1'b1;
                r_ver[w_tgt]   <= i_wrVersion;
                r_data[w_tgt]  <= i_wrData;
                r_lastVer      <= i_wrVersion;
                r_lastVerValid <= 1'b1;
            end
            if (w_wrElig) r_lastWasWrite <= 1'b1;
            if (w_readGo) begin
                r_reqVer       <= w_reqVer[w_gntId];
                r_reqId        <= w_gntId;
                r_rrPtr        <= (w_gntId == ID_W'(REQ_NUM - 1)) ? '0 : w_gntId + 1'b1;
                r_lastWasWrite <= 1'b0;
            end
            if (r_state == LOOKUP) begin
                o_rspValid <= 1'b1;
                o_rspHit   <= w_hit;
                o_rspData  <= w_hitData;
                o_rspId    <= r_reqId;
            end else if (r_state == RESP && i_rspReady) begin
                o_rspValid <= 1'b0;
            end
        end
    end

`ifdef VERSION_READ_ARBITER_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            o_hitCount  <= '0;
            o_missCount <= '0;
            o_rejCount  <= '0;
        end else begin
            if (r_state == LOOKUP && w_hit && !(&o_hitCount)) o_hitCount <= o_hitCount + 1'b1;
            if (r_state == LOOKUP && !w_hit && !(&o_missCount)) o_missCount <= o_missCount + 1'b1;
            if (o_wrErr && !(&o_rejCount)) o_rejCount <= o_rejCount + 1'b1;
        end
    end
`endif
endmodule

// File: doc/version_read_arbiter.md
# version_read_arbiter

Shared read/write controller for the multi-version data store. It owns VERSION_NUM (data, version) slots and serialises one writer and REQ_NUM round-robin readers onto a single lookup path. For a read at version V, the lookup returns the newest stored version that is ≤ V. It sits between the transaction front-end and the version storage, and exposes one registered response bus tagged with the requester id.

## Interface
- DATA_WIDTH, 32, payload width
- VERSION_WIDTH, 4, version tag width (unsigned)
- VERSION_NUM, 4, number of version slots
- REQ_NUM, 2, number of read requesters (≥1)

- clk  in  1  clock; all logic on the rising edge
- rstN  in  1  synchronous, active-low reset
- wrValid  in  1  write request
- wrVersion  in  VERSION_WIDTH  version tag of write
- wrData  in  DATA_WIDTH  write payload
- wrReady  out  1  write accepted this cycle
- wrErr  out  1  one-cycle pulse: write rejected (non-monotonic)
- reqValid  in  REQ_NUM  per-requester read request
- reqVersion  in  REQ_NUM*VERSION_WIDTH  read version, requester i at bits [i*VERSION_WIDTH +: VERSION_WIDTH]
- reqReady  out  REQ_NUM  one-hot grant; request accepted this cycle
- rspValid  out  1  response valid
- rspReady  in  1  response consumer ready
- rspId  out  $clog2(REQ_NUM) (min 1)  requester index of response
- rspHit  out  1  a matching slot was found
- rspData  out  DATA_WIDTH  matched data; 0 on miss

## Operation
- Slot state: valid bit, version, and data per slot. All slots are invalid after reset. lastVer register and lastVerValid=0.
- FSM has three states: IDLE, LOOKUP, RESP.
- IDLE, write path:
  - A write is eligible if wrValid=1 and NOT (a read is pending and lastWasWrite=1).
  - Accept when lastVerValid=0 or wrVersion > lastVer. Otherwise pulse wrErr, pulse wrReady (consumed), and leave the store unchanged.
  - Target slot: lowest-index invalid slot; if none, the slot holding the smallest version (eviction).
  - Update lastVer. State stays IDLE. Set lastWasWrite=1.
- IDLE, read path:
  - Taken when no write is accepted and any reqValid=1.
  - Round-robin grant starts from rrPtr; reqReady is one-hot on the granted index.
  - Latch version and id, set rrPtr=(grant+1) mod REQ_NUM, lastWasWrite=0, go to LOOKUP.
- Write and read in the same IDLE cycle: the write wins unless the previous accepted op was a write. This strict alternation prevents starvation.
- LOOKUP:
  - Select the valid slot with the largest version ≤ latched version. Versions are unique, so no ties arise.
  - Register rspHit/rspData/rspId, assert rspValid, go to RESP.
- RESP: hold all rsp* stable while rspValid=1 and rspReady=0. On rspReady=1, drop rspValid and return to IDLE.
- wrReady=0 and reqReady=0 outside IDLE.
- Comparisons are unsigned with no wrap. Once lastVer = 2^VERSION_WIDTH-1, every further write is rejected until reset.

## Timing
- Reset values: wrReady=0, wrErr=0, reqReady=0, rspValid=0, rspId=0, rspHit=0, rspData=0; rrPtr=0, lastWasWrite=0, state IDLE.
- Reset asserted mid-operation aborts any pending response; rspValid=0 on the next edge.
- Write: accepted in 1 cycle. Store is updated at the accepting edge and is visible to a lookup started in the next cycle.
- Read: accept at edge N; rspValid=1 after edge N+1 (latency 2). Throughput is at most one read per 3 cycles with rspReady tied high.
- wrReady and reqReady are combinational from state and inputs. All rsp* outputs are registered.

## Configuration
- VERSION_READ_ARBITER_STATS_EN
  - Defined: adds outputs hitCount and missCount (32 bits each, reset 0, saturating). One of them increments when a response enters RESP. Adds rejCount (16 bits, saturating), which increments on each wrErr.
  - Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then read at version 5 from req0 → rspHit=0, rspData=0, rspId=0, rspValid 2 cycles after reqReady.
- Writes (v1, 0xA), (v3, 0xB), (v7, 0xC); read at v5 → hit, 0xB; read at v0 → miss; read at v15 → 0xC.
- Fill 4 slots with v1..v4, then write v9 → v1 evicted. Read at v1 → miss; read at v2 → v2 data.
- Write v6 after v6, then v4 → wrErr pulses twice and the store is unchanged. With STATS_EN, rejCount=2.
- reqValid=2'b11 held continuously, rspReady=1 → grants alternate 0,1,0,1 and rspId matches each grant.
- wrValid and reqValid held together → accepted ops alternate write/read. Hold rspReady=0 for 5 cycles in RESP → rsp* stable. Assert rstN=0 in RESP → rspValid=0 next edge and all slots are invalid.
